// File: rtl/bz_router_pkg.sv
// Shared router definitions: flit geometry, the arbiter state type and
// small elaboration-time helpers used by the flit arbiter and its picker.
package bz_router_pkg;

    // Default flit width; the most significant flit bit marks a packet tail.
    localparam int BZ_FLIT_W   = 11;
    localparam int BZ_TAIL_BIT = BZ_FLIT_W - 1;

    // Wormhole arbiter states.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Tail bit position for an arbitrary flit width.
    function automatic int bz_tail_bit(input int flit_w);
        return flit_w - 1;
    endfunction

    // Index width for a requester count; never narrower than one bit.
    function automatic int bz_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bz_rr_picker.sv
// Round-robin picker: first eligible requester at or after rr_ptr,
// wrapping modulo NREQ. Purely combinational.
module bz_rr_picker
    import bz_router_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = bz_idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] cand;

    // Scan from rr_ptr upward and keep the first eligible candidate.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/bz_flit_arbiter.sv
// Wormhole flit arbiter: NREQ serializers share one router FIFO. A
// requester holds the FIFO from grant until its tail flit is written, so
// packets never interleave. Round-robin fairness among eligible requesters.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no holder; selecting a winner, no flit accepted this cycle
// LOCKED | grant_idx owns the FIFO until a tail flit is actually written
module bz_flit_arbiter
    import bz_router_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int FLIT_W = BZ_FLIT_W,
    localparam int IDX_W  = bz_idx_w(NREQ),
    localparam int TAIL   = bz_tail_bit(FLIT_W)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               req_wrreq,
    input  logic [NREQ-1:0][FLIT_W-1:0]   req_data,
    output logic [NREQ-1:0]               req_full,
    input  logic [NREQ-1:0]               enable_mask,
    input  logic                          is_full,
    output logic                          wrreq,
    output logic [FLIT_W-1:0]             data_out,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic [15:0]                   pkt_count
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] ptr_after_grant;
    logic [IDX_W-1:0] pick_ptr;
    logic [IDX_W-1:0] winner;
    logic [NREQ-1:0]  eligible;
    logic             found;
    logic             locked;
    logic             release_pkt;
    logic [15:0]      pkt_count_q;

    assign eligible = req & enable_mask;
    assign locked   = (state_q == ARB_LOCKED);

    // Pointer just past the holder; the released requester becomes lowest priority.
    always_comb begin
        if (grant_q == IDX_W'(NREQ - 1)) begin
            ptr_after_grant = '0;
        end else begin
            ptr_after_grant = grant_q + IDX_W'(1);
        end
    end

    // While locked the picker only matters on release, where it must already
    // see the advanced pointer so re-arbitration happens in the same cycle.
    assign pick_ptr = locked ? ptr_after_grant : rr_ptr_q;

    bz_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .eligible (eligible),
        .rr_ptr   (pick_ptr),
        .found    (found),
        .winner   (winner)
    );

    // Zero-latency steering of the holder's flit path; everyone else stalls.
    always_comb begin
        wrreq    = 1'b0;
        data_out = '0;
        req_full = '1;
        if (locked) begin
            data_out          = req_data[grant_q];
            wrreq             = req_wrreq[grant_q] & ~is_full;
            req_full[grant_q] = is_full;
        end
    end

    // A lock ends only when a tail flit actually enters the FIFO.
    assign release_pkt = wrreq & data_out[TAIL];

    // Next-state: grant from IDLE, or release and optionally regrant while LOCKED.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_LOCKED;
                    grant_d = winner;
                end
            end
            ARB_LOCKED: begin
                if (release_pkt) begin
                    rr_ptr_d = ptr_after_grant;
                    if (found) begin
                        grant_d = winner;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, holder and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Completed-packet counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count_q <= '0;
        end else if (release_pkt) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign grant_valid = locked;
    assign grant_idx   = grant_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: doc/bz_flit_arbiter.md
BZ_FLIT_ARBITER -- requirements
Module: bz_flit_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of serializer requesters sharing one router FIFO.
REQ-002 Parameter FLIT_W, default 11: flit width; bit FLIT_W-1 is the tail bit.
REQ-003 Port clk  input  1: single clock; all state on rising edge.
REQ-004 Port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-005 Port req  input  NREQ: requester i has a packet pending (driven from its core channel valid).
REQ-006 Port req_wrreq  input  NREQ: per-requester flit write request.
REQ-007 Port req_data  input  NREQ x FLIT_W: per-requester flit.
REQ-008 Port req_full  output  NREQ: per-requester full/stall indication.
REQ-009 Port enable_mask  input  NREQ: requester i is eligible for new grants only when bit i is 1.
REQ-010 Port is_full  input  1: shared FIFO full.
REQ-011 Port wrreq  output  1: shared FIFO write request.
REQ-012 Port data_out  output  FLIT_W: flit to shared FIFO.
REQ-013 Port grant_valid  output  1: a requester currently holds the FIFO.
REQ-014 Port grant_idx  output  clog2(NREQ): index of the holder; 0 when grant_valid is 0.
REQ-015 Port pkt_count  output  16: count of tail flits written; wraps 0xFFFF->0.

Function
REQ-016 FSM has two states, IDLE and LOCKED; packets are never interleaved (wormhole lock).
REQ-017 Eligible set = req & enable_mask; IDLE with a non-empty eligible set picks the winner round-robin starting at pointer rr_ptr and enters LOCKED next cycle with grant_idx = winner.
REQ-018 One-cycle grant latency: the winner's req_full deasserts in the cycle after selection; no flit is accepted in the selection cycle.
REQ-019 While LOCKED: req_full[grant_idx] = is_full; every other req_full bit = 1.
REQ-020 While LOCKED: data_out = req_data[grant_idx], wrreq = req_wrreq[grant_idx] & !is_full (combinational path, zero latency).
REQ-021 In IDLE: wrreq = 0, data_out = 0, all req_full = 1.
REQ-022 req_wrreq from non-granted requesters is ignored and never reaches wrreq.
REQ-023 Release occurs only on the cycle wrreq=1 with data_out tail bit=1; rr_ptr then becomes (grant_idx+1) mod NREQ.
REQ-024 On release, if the eligible set is non-empty, arbitrate in that same cycle with the updated rr_ptr (released requester lowest priority) and stay LOCKED with the new grant_idx; otherwise return to IDLE.
REQ-025 A tail flit presented while is_full=1 is not written and does not release the lock.
REQ-026 Deassertion of req or of enable_mask by the holder while LOCKED does not release; only a written tail releases.
REQ-027 pkt_count increments by 1 on every release.
REQ-028 Single-requester case: back-to-back packets from one requester are granted with no idle cycle between them (REQ-024).

Reset
REQ-029 While reset=0: state IDLE, rr_ptr=0, grant_valid=0, grant_idx=0, pkt_count=0, wrreq=0, data_out=0, all req_full=1.
REQ-030 Reset asserted mid-packet discards the lock; after release of reset, arbitration restarts from rr_ptr=0 and the partial packet is not completed by this block.

Structure
REQ-031 FLIT_W, the tail bit position and the IDLE/LOCKED state enum live in the shared router package (bz_router_pkg).
REQ-032 Round-robin selection is one combinational sub-module, bz_rr_picker (inputs eligible and rr_ptr; outputs found and winner).

Verification
REQ-033 Reset low mid-packet with requester 2 locked -> req_full=4'b1111, grant_valid=0, pkt_count=0; after reset high, req=4'b0100 -> grant_idx=2 one cycle later.
REQ-034 req=4'b1111 held, each requester sending 4-flit packets (header, 2 data, tail) -> grants in order 0,1,2,3,0; no flit interleaving; pkt_count=5 after 20 written flits.
REQ-035 Requester 1 locked, is_full=1 on its tail flit for 3 cycles -> wrreq=0 for those cycles, lock held; tail written on the 4th cycle, then release.
REQ-036 Requester 0 locked, requester 3 asserts req_wrreq with data 0x7FF -> data_out never shows 0x7FF and wrreq tracks requester 0 only.
REQ-037 enable_mask=4'b1011, req=4'b0100 -> no grant; mask changed to 4'b1111 -> grant_idx=2 next cycle; mask cleared while locked -> lock held until tail.
REQ-038 pkt_count preloaded via 65,535 single-flit tail packets, one more packet -> pkt_count wraps to 0.
